// File: rtl/mcycle_pkg.sv
// Shared types and helpers for the multi-cycle multiply/divide unit.
package mcycle_pkg;

  // Widest operand the magnitude helper handles.
  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    OP_MUL_S = 2'b00,
    OP_MUL_U = 2'b01,
    OP_DIV_S = 2'b10,
    OP_DIV_U = 2'b11
  } mcycle_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } mcycle_state_e;

  // Operation attributes latched at accept.
  typedef struct packed {
    logic is_div;
    logic neg_res;
    logic neg_rem;
  } op_info_t;

  // Two's-complement magnitude of a zero-extended operand whose sign is given separately.
  function automatic logic [MAX_W-1:0] abs_twos(input logic [MAX_W-1:0] x, input logic is_neg);
    return is_neg ? (~x + MAX_W'(1)) : x;
  endfunction

endpackage

// File: rtl/mcycle_addsub.sv
// N-bit adder/subtractor with carry out; sub=1 computes a - b as a + ~b + 1.
module mcycle_addsub #(
  parameter int unsigned N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] full;

  // Single carry-propagate add with optional operand inversion.
  always_comb begin
    full = (N+1)'(a) + (N+1)'(b ^ {N{sub}}) + (N+1)'(sub);
  end

  assign sum  = full[N-1:0];
  assign cout = full[N];

endmodule

// File: rtl/mcycle_ext.sv
// Multi-cycle signed/unsigned multiply and divide, one bit per cycle.
module mcycle_ext
  import mcycle_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned AW    = WIDTH + 1;

  mcycle_state_e      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  op_info_t           info_q, info_d;
  logic [WIDTH-1:0]   res1_q, res1_d;
  logic [WIDTH-1:0]   res2_q, res2_d;
  logic               dbz_q, dbz_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [WIDTH-1:0] mag1, mag2;
  logic             neg1, neg2, is_div_in, is_signed_in;
  mcycle_op_e       op_in;

  logic [AW-1:0] as0_a, as0_b, as0_sum, as1_a, as1_b, as1_sum;
  logic          as0_sub, as0_cout, as1_sub, as1_cout;
  logic          unused_bits;

  assign acc_hi = acc_q[2*WIDTH-1:WIDTH];
  assign acc_lo = acc_q[WIDTH-1:0];

  assign op_in        = mcycle_op_e'(MCycleOp);
  assign is_div_in    = (op_in == OP_DIV_S) || (op_in == OP_DIV_U);
  assign is_signed_in = (op_in == OP_MUL_S) || (op_in == OP_DIV_S);
  assign neg1         = is_signed_in & Operand1[WIDTH-1];
  assign neg2         = is_signed_in & Operand2[WIDTH-1];
  assign mag1         = WIDTH'(abs_twos(MAX_W'(Operand1), neg1));
  assign mag2         = WIDTH'(abs_twos(MAX_W'(Operand2), neg2));

  // Iteration adder; in FIX it negates the low half / quotient.
  mcycle_addsub #(.N(AW)) u_as0 (
    .a(as0_a), .b(as0_b), .sub(as0_sub), .sum(as0_sum), .cout(as0_cout)
  );

  // FIX-only adder: negates the high half (with borrow from low) or the remainder.
  mcycle_addsub #(.N(AW)) u_as1 (
    .a(as1_a), .b(as1_b), .sub(as1_sub), .sum(as1_sum), .cout(as1_cout)
  );

  assign unused_bits = ^{as1_cout, as1_sum[WIDTH]};

  // Adder operand selection per state and operation.
  always_comb begin
    as0_a   = '0;
    as0_b   = '0;
    as0_sub = 1'b0;
    as1_a   = '0;
    as1_b   = '0;
    as1_sub = 1'b0;
    if (state_q == ST_FIX) begin
      as0_b   = {1'b0, acc_lo};
      as0_sub = 1'b1;
      if (info_q.is_div) begin
        as1_b   = {1'b0, acc_hi};
        as1_sub = 1'b1;
      end else begin
        as1_a = {1'b0, ~acc_hi};
        as1_b = AW'(as0_cout);
      end
    end else if (info_q.is_div) begin
      as0_a   = {acc_hi, acc_lo[WIDTH-1]};
      as0_b   = {1'b0, opb_q};
      as0_sub = 1'b1;
    end else begin
      as0_a = {1'b0, acc_hi};
      as0_b = {1'b0, opb_q};
    end
  end

  // Next-state, datapath and result update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    info_d  = info_q;
    res1_d  = res1_q;
    res2_d  = res2_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          res1_d         = '0;
          res2_d         = '0;
          dbz_d          = 1'b0;
          cnt_d          = '0;
          info_d.is_div  = is_div_in;
          info_d.neg_res = neg1 ^ neg2;
          info_d.neg_rem = neg1;
          if (is_div_in && (Operand2 == '0)) begin
            res1_d  = '1;
            res2_d  = Operand1;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            acc_d   = {WIDTH'(0), mag1};
            opb_d   = mag2;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (info_q.is_div) begin
          acc_d = as0_cout ? {as0_sum[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1}
                           : {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1], acc_lo[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = acc_lo[0] ? {as0_sum, acc_lo[WIDTH-1:1]}
                            : {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          cnt_d   = '0;
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        res1_d = info_q.neg_res ? as0_sum[WIDTH-1:0] : acc_lo;
        if (info_q.is_div) res2_d = info_q.neg_rem ? as1_sum[WIDTH-1:0] : acc_hi;
        else               res2_d = info_q.neg_res ? as1_sum[WIDTH-1:0] : acc_hi;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      info_q  <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      info_q  <= info_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign Busy      = ((state_q == ST_IDLE) && Start) || (state_q == ST_RUN) || (state_q == ST_FIX);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign Result1   = res1_q;
  assign Result2   = res2_q;

endmodule

// File: tb/tb_mcycle_ext.sv
// Self-checking bench for mcycle_ext (WIDTH = 32) against an arithmetic reference model.
module tb_mcycle_ext;

  localparam int LAT = 34;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  MCycleOp = 2'b00;
  logic [31:0] Operand1 = '0;
  logic [31:0] Operand2 = '0;
  logic [31:0] Result1, Result2;
  logic        Busy, Done, DivByZero;

  int n_checks = 0;
  int n_pass   = 0;

  mcycle_ext #(.WIDTH(32)) dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2), .Result1(Result1), .Result2(Result2),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero)
  );

  initial forever #5 CLK = ~CLK;

  // Reference: plain 64-bit arithmetic with SV truncating division.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r1, output logic [31:0] r2, output logic dbz);
    longint sa, sb, q, r;
    longint unsigned p, ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    dbz = 1'b0;
    r1 = '0;
    r2 = '0;
    if (op[1] == 1'b0) begin
      if (op[0] == 1'b0) p = 64'(sa * sb);
      else               p = ua * ub;
      r1 = p[31:0];
      r2 = p[63:32];
    end else if (b == 32'h0) begin
      r1 = 32'hFFFF_FFFF;
      r2 = a;
      dbz = 1'b1;
    end else if (op[0] == 1'b0) begin
      q = sa / sb;
      r = sa % sb;
      r1 = q[31:0];
      r2 = r[31:0];
    end else begin
      p = ua / ub;
      r1 = p[31:0];
      p = ua % ub;
      r2 = p[31:0];
    end
  endfunction

  // Drives one request and waits (bounded) for Done; returns latency and Busy profile.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output bit busy_ok);
    int c;
    @(negedge CLK);
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
    #1;
    busy_ok = (Busy === 1'b1);
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0; Operand1 = $urandom; Operand2 = $urandom; MCycleOp = 2'($urandom);
    lat = -1;
    c = 1;
    while (lat < 0 && c <= 100) begin
      if (Done === 1'b1) begin
        lat = c;
        if (Busy !== 1'b0) busy_ok = 1'b0;
      end else begin
        if (Busy !== 1'b1) busy_ok = 1'b0;
        @(negedge CLK);
        c++;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({Result1, Result2, Busy, Done, DivByZero} !== 67'h0)
      $display("FAIL reset_outputs: got r1=%h r2=%h busy=%b done=%b dbz=%b want all 0",
               Result1, Result2, Busy, Done, DivByZero);
    else n_pass++;
    RESET = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0]  ops[6];
    logic [31:0] aa[6], bb[6], e1[6], e2[6];
    int lat;
    bit bok;
    ops = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10};
    aa  = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFF9, 32'd7,        32'h80000000};
    bb  = '{32'hFFFFFFFF, 32'd7,        32'h80000000, 32'd2,        32'hFFFFFFFE, 32'hFFFFFFFF};
    e1  = '{32'h00000001, 32'hFFFFFFEB, 32'h00000000, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000};
    e2  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], aa[i], bb[i], lat, bok);
      n_checks++;
      if (lat !== LAT) $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, LAT);
      else n_pass++;
      n_checks++;
      if (!bok) $display("FAIL directed%0d_busy: got bad profile want high 0..%0d low at %0d", i, LAT-1, LAT);
      else n_pass++;
      n_checks++;
      if (Result1 !== e1[i]) $display("FAIL directed%0d_result1: got %h want %h", i, Result1, e1[i]);
      else n_pass++;
      n_checks++;
      if (Result2 !== e2[i]) $display("FAIL directed%0d_result2: got %h want %h", i, Result2, e2[i]);
      else n_pass++;
      n_checks++;
      if (DivByZero !== 1'b0) $display("FAIL directed%0d_dbz: got %b want 0", i, DivByZero);
      else n_pass++;
    end
  endtask

  task automatic test_div_by_zero();
    int lat;
    bit bok;
    issue(2'b11, 32'd100, 32'd0, lat, bok);
    n_checks++;
    if (lat !== 1 || !bok) $display("FAIL dbz_latency: got lat=%0d busy_ok=%b want 1/1", lat, bok);
    else n_pass++;
    n_checks++;
    if ({DivByZero, Result1, Result2} !== {1'b1, 32'hFFFFFFFF, 32'd100})
      $display("FAIL dbz_results: got dbz=%b r1=%h r2=%h want 1 ffffffff 00000064", DivByZero, Result1, Result2);
    else n_pass++;
    issue(2'b11, 32'd100, 32'd7, lat, bok);
    n_checks++;
    if (lat !== LAT) $display("FAIL dbz_next_latency: got %0d want %0d", lat, LAT);
    else n_pass++;
    n_checks++;
    if ({DivByZero, Result1, Result2} !== {1'b0, 32'd14, 32'd2})
      $display("FAIL dbz_next_results: got dbz=%b r1=%h r2=%h want 0 0000000e 00000002", DivByZero, Result1, Result2);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] edges[5];
    logic [31:0] a, b, x1, x2;
    logic [1:0]  op;
    logic        xd;
    int lat;
    bit bok;
    edges = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : 32'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : 32'($urandom);
      if (i % 5 == 1) b = 32'($urandom_range(1, 15));
      model(op, a, b, x1, x2, xd);
      issue(op, a, b, lat, bok);
      n_checks++;
      if (lat !== (xd ? 1 : LAT) || !bok)
        $display("FAIL rand%0d_timing: got lat=%0d busy_ok=%b want lat=%0d busy_ok=1", i, lat, bok, xd ? 1 : LAT);
      else n_pass++;
      n_checks++;
      if ({Result1, Result2, DivByZero} !== {x1, x2, xd})
        $display("FAIL rand%0d_op%0d a=%h b=%h: got r1=%h r2=%h dbz=%b want r1=%h r2=%h dbz=%b",
                 i, op, a, b, Result1, Result2, DivByZero, x1, x2, xd);
      else n_pass++;
    end
  endtask

  task automatic test_ignored_start();
    logic [31:0] a1, a2, b1, b2, h1, h2, z1, z2, g1, g2, ea1, ea2, eb1, eb2;
    logic        ad, bd, busy35, done35, xd;
    int early;
    model(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, ea1, ea2, xd);
    model(2'b10, 32'hFFFFFFF9, 32'd2, eb1, eb2, xd);
    early = 0;
    @(negedge CLK);
    Start = 1'b1; MCycleOp = 2'b01; Operand1 = 32'hFFFFFFFF; Operand2 = 32'hFFFFFFFF;
    @(posedge CLK);
    for (int c = 1; c <= 70; c++) begin
      @(negedge CLK);
      if (c == 1) begin MCycleOp = 2'b10; Operand1 = 32'hFFFFFFF9; Operand2 = 32'd2; end
      if ((c < 34 || (c > 35 && c < 69)) && Done === 1'b1) early++;
      if (c == 34) begin ad = Done; a1 = Result1; a2 = Result2; end
      if (c == 35) begin busy35 = Busy; done35 = Done; h1 = Result1; h2 = Result2; end
      if (c == 36) begin z1 = Result1; z2 = Result2; end
      if (c == 69) begin bd = Done; g1 = Result1; g2 = Result2; Start = 1'b0; end
    end
    n_checks++;
    if (early !== 0) $display("FAIL ign_early_done: got %0d early Done cycles want 0", early);
    else n_pass++;
    n_checks++;
    if ({ad, a1, a2} !== {1'b1, ea1, ea2})
      $display("FAIL ign_first: got done=%b r1=%h r2=%h want 1 %h %h", ad, a1, a2, ea1, ea2);
    else n_pass++;
    n_checks++;
    if ({busy35, done35, h1, h2} !== {1'b1, 1'b0, ea1, ea2})
      $display("FAIL ign_cycle35: got busy=%b done=%b r1=%h r2=%h want 1 0 %h %h", busy35, done35, h1, h2, ea1, ea2);
    else n_pass++;
    n_checks++;
    if ({z1, z2} !== 64'h0) $display("FAIL ign_clear_at_accept: got r1=%h r2=%h want 0 0", z1, z2);
    else n_pass++;
    n_checks++;
    if ({bd, g1, g2} !== {1'b1, eb1, eb2})
      $display("FAIL ign_second: got done=%b r1=%h r2=%h want 1 %h %h", bd, g1, g2, eb1, eb2);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat;
    bit bok;
    @(negedge CLK);
    Start = 1'b1; MCycleOp = 2'b01; Operand1 = $urandom; Operand2 = $urandom;
    @(posedge CLK);
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      Start = 1'b0;
      if (c == 10) RESET = 1'b1;
    end
    @(negedge CLK);
    n_checks++;
    if ({Result1, Result2, Busy, Done, DivByZero} !== 67'h0)
      $display("FAIL reset_mid_outputs: got r1=%h r2=%h busy=%b done=%b dbz=%b want all 0",
               Result1, Result2, Busy, Done, DivByZero);
    else n_pass++;
    RESET = 1'b0;
    issue(2'b00, 32'd6, 32'd7, lat, bok);
    n_checks++;
    if (lat !== LAT || !bok) $display("FAIL reset_mid_latency: got lat=%0d busy_ok=%b want %0d/1", lat, bok, LAT);
    else n_pass++;
    n_checks++;
    if ({Result1, Result2} !== {32'd42, 32'd0})
      $display("FAIL reset_mid_result: got r1=%h r2=%h want 0000002a 00000000", Result1, Result2);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_by_zero();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
